// File: rtl/apb2axil_pkg.sv
// Shared types for the APB -> AXI4-Lite bridge: FSM states and AXI response codes.
package apb2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        ERR,
        DONE
    } state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input resp_t r);
        logic err;
        case (r)
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            default:                  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb2axil_bridge_if.sv
// APB completer face plus AXI4-Lite manager face of the bridge.
// slave: the bridge's own view; master: the APB requester and AXI peripheral opposite it.
interface apb2axil_bridge_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    localparam int STRBWIDTH = DATAWIDTH / 8;

    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [DATAWIDTH-1:0] pwdata;
    logic [STRBWIDTH-1:0] pstrb;
    logic [2:0]           pprot;
    logic                 pready;
    logic [DATAWIDTH-1:0] prdata;
    logic                 pslverr;

    logic [ADDRWIDTH-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [DATAWIDTH-1:0] wdata;
    logic [STRBWIDTH-1:0] wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDRWIDTH-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [DATAWIDTH-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/apb2axil_bridge.sv
// APB completer re-issuing each transfer as one AXI4-Lite transaction; pready at A+3 (A+2 on window miss).
// Single outstanding: the APB access phase stalls until the AXI response returns.
module apb2axil_bridge
    import apb2axil_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter int                   ADDRWIDTH = 32,
    parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0,
    parameter logic [ADDRWIDTH-1:0] ADDR_MASK = '0
) (
    input logic              clk,
    input logic              rst,
    apb2axil_bridge_if.slave bus
);
    localparam int STRBWIDTH = DATAWIDTH / 8;

    state_t               state_q, state_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                 bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                 pready_q, pready_d, pslverr_q, pslverr_d;
    logic [DATAWIDTH-1:0] prdata_q, prdata_d, wdata_q, wdata_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [STRBWIDTH-1:0] strb_q, strb_d;
    logic [2:0]           prot_q, prot_d;
    logic                 win_hit;

    assign win_hit = ((bus.paddr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.psel && bus.penable) begin
                    addr_d  = bus.paddr;
                    wdata_d = bus.pwdata;
                    strb_d  = bus.pstrb;
                    prot_d  = bus.pprot;
                    if (!win_hit) begin
                        state_d = ERR;
                    end else if (bus.pwrite) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; either may finish first or both together.
                aw_done_d = aw_done_q | (awvalid_q & bus.awready);
                w_done_d  = w_done_q | (wvalid_q & bus.wready);
                awvalid_d = awvalid_q & ~bus.awready;
                wvalid_d  = wvalid_q & ~bus.wready;
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    state_d   = DONE;
                    bready_d  = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(bus.bresp);
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (bus.rvalid) begin
                    state_d   = DONE;
                    rready_d  = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(bus.rresp);
                    prdata_d  = bus.rdata;
                end
            end
            ERR: begin
                state_d   = DONE;
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
    assign bus.awaddr  = addr_q;
    assign bus.awprot  = prot_q;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = strb_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;
    assign bus.araddr  = addr_q;
    assign bus.arprot  = prot_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

endmodule

// File: tb/tb_apb2axil_bridge.sv
// Directed bench for apb2axil_bridge: APB requester, delay-configurable AXI4-Lite peripheral, scoreboard queues.
module tb_apb2axil_bridge;
    import apb2axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    apb2axil_bridge_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus0 ();
    apb2axil_bridge_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus1 ();

    apb2axil_bridge #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    apb2axil_bridge #(.DATAWIDTH(DW), .ADDRWIDTH(AW),
                      .BASE_ADDR(32'h0000_1000), .ADDR_MASK(32'h0000_F000)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } areq_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } wreq_t;
    typedef struct { logic [DW-1:0] prdata; logic pslverr; int lat; } apb_exp_t;

    areq_t    exp_aw[$];
    areq_t    exp_ar[$];
    wreq_t    exp_w[$];
    apb_exp_t exp_apb[$];

    int checks   = 0;
    int failures = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    resp_t bresp_cfg = RESP_OKAY;
    resp_t rresp_cfg = RESP_OKAY;
    logic [DW-1:0] rdata_cfg = '0;

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit aw_got = 0, w_got = 0, b_pending = 0, r_pending = 0;
    bit viol1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // AXI4-Lite peripheral: decisions made at negedge apply to the following posedge.
    initial begin : axi_slave
        areq_t a;
        wreq_t w;
        bus0.awready = 1'b0; bus0.wready = 1'b0; bus0.bvalid = 1'b0; bus0.bresp = RESP_OKAY;
        bus0.arready = 1'b0; bus0.rvalid = 1'b0; bus0.rdata = '0;    bus0.rresp = RESP_OKAY;
        forever begin
            @(negedge clk);
            bus0.bvalid = 1'b0;
            if (b_pending) begin
                if (b_wait >= b_dly) begin
                    bus0.bvalid = 1'b1;
                    bus0.bresp  = bresp_cfg;
                    if (bus0.bready) begin b_pending = 0; b_wait = 0; b_cnt++; end
                end else b_wait++;
            end
            bus0.rvalid = 1'b0;
            if (r_pending) begin
                if (r_wait >= r_dly) begin
                    bus0.rvalid = 1'b1;
                    bus0.rdata  = rdata_cfg;
                    bus0.rresp  = rresp_cfg;
                    if (bus0.rready) begin r_pending = 0; r_wait = 0; r_cnt++; end
                end else r_wait++;
            end
            if (aw_got) chk("awvalid_dropped_after_hs", bus0.awvalid, 1'b0);
            bus0.awready = 1'b0;
            if (bus0.awvalid) begin
                if (aw_wait >= aw_dly) begin
                    bus0.awready = 1'b1; aw_wait = 0; aw_cnt++; aw_got = 1;
                    chk("aw_expected", exp_aw.size() > 0, 1'b1);
                    if (exp_aw.size() > 0) begin
                        a = exp_aw.pop_front();
                        chk("awaddr", bus0.awaddr, a.addr);
                        chk("awprot", bus0.awprot, a.prot);
                    end
                end else aw_wait++;
            end else aw_wait = 0;
            bus0.wready = 1'b0;
            if (bus0.wvalid) begin
                if (w_wait >= w_dly) begin
                    bus0.wready = 1'b1; w_wait = 0; w_cnt++; w_got = 1;
                    chk("w_expected", exp_w.size() > 0, 1'b1);
                    if (exp_w.size() > 0) begin
                        w = exp_w.pop_front();
                        chk("wdata", bus0.wdata, w.data);
                        chk("wstrb", bus0.wstrb, w.strb);
                    end
                end else begin
                    w_wait++;
                    if (exp_w.size() > 0) begin
                        chk("wdata_stable", bus0.wdata, exp_w[0].data);
                        chk("wstrb_stable", bus0.wstrb, exp_w[0].strb);
                    end
                end
            end else w_wait = 0;
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pending = 1; b_wait = 0; end
            bus0.arready = 1'b0;
            if (bus0.arvalid) begin
                if (ar_wait >= ar_dly) begin
                    bus0.arready = 1'b1; ar_wait = 0; ar_cnt++; r_pending = 1; r_wait = 0;
                    chk("ar_expected", exp_ar.size() > 0, 1'b1);
                    if (exp_ar.size() > 0) begin
                        a = exp_ar.pop_front();
                        chk("araddr", bus0.araddr, a.addr);
                        chk("arprot", bus0.arprot, a.prot);
                    end
                end else ar_wait++;
            end else ar_wait = 0;
        end
    end

    always @(negedge clk)
        if (bus1.awvalid || bus1.wvalid || bus1.arvalid || bus1.bready || bus1.rready) viol1 = 1;

    // Called and returning at a negedge; psel/penable stay high until the caller changes them.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [2:0] prot, input int lat,
                            input logic [DW-1:0] exp_rd, input logic exp_err);
        apb_exp_t e;
        bit seen = 0;
        e.prdata = exp_rd; e.pslverr = exp_err; e.lat = lat;
        exp_apb.push_back(e);
        if (wr) begin
            exp_aw.push_back(areq_t'{addr, prot});
            exp_w.push_back(wreq_t'{data, strb});
        end else begin
            exp_ar.push_back(areq_t'{addr, prot});
        end
        bus0.psel = 1'b1; bus0.penable = 1'b0; bus0.pwrite = wr; bus0.paddr = addr;
        bus0.pwdata = data; bus0.pstrb = strb; bus0.pprot = prot;
        @(negedge clk);
        bus0.penable = 1'b1;
        chk("pready_first_access", bus0.pready, 1'b0);
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (bus0.pready) begin
                seen = 1;
                e = exp_apb.pop_front();
                chk("pready_latency", k, e.lat);
                chk("prdata", bus0.prdata, e.prdata);
                chk("pslverr", bus0.pslverr, e.pslverr);
            end
        end
        chk("pready_seen", seen, 1'b1);
        if (!seen) e = exp_apb.pop_front();
        @(negedge clk);
        chk("pready_single_cycle", bus0.pready, 1'b0);
    endtask

    task automatic idle(input int n);
        bus0.psel = 1'b0; bus0.penable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;
        int aw0, w0, b0, ar0, r0;
        bus0.psel = 1'b0; bus0.penable = 1'b0; bus0.pwrite = 1'b0; bus0.paddr = '0;
        bus0.pwdata = '0; bus0.pstrb = '0; bus0.pprot = '0;
        bus1.psel = 1'b0; bus1.penable = 1'b0; bus1.pwrite = 1'b0; bus1.paddr = '0;
        bus1.pwdata = '0; bus1.pstrb = '0; bus1.pprot = '0;
        bus1.awready = 1'b1; bus1.wready = 1'b1; bus1.arready = 1'b1;
        bus1.bvalid = 1'b0; bus1.bresp = RESP_OKAY; bus1.rvalid = 1'b0;
        bus1.rdata = '0; bus1.rresp = RESP_OKAY;

        repeat (2) @(negedge clk);
        chk("rst_pready",  bus0.pready,  1'b0);
        chk("rst_pslverr", bus0.pslverr, 1'b0);
        chk("rst_prdata",  bus0.prdata,  32'h0);
        chk("rst_awvalid", bus0.awvalid, 1'b0);
        chk("rst_wvalid",  bus0.wvalid,  1'b0);
        chk("rst_arvalid", bus0.arvalid, 1'b0);
        chk("rst_bready",  bus0.bready,  1'b0);
        chk("rst_rready",  bus0.rready,  1'b0);
        chk("rst_awaddr",  bus0.awaddr,  32'h0);
        chk("rst_wdata",   bus0.wdata,   32'h0);
        rst = 1'b1;
        @(negedge clk);

        // zero-wait write
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 3, 32'h0, 1'b0);
        idle(2);
        chk("t1_aw_count", aw_cnt - aw0, 1);
        chk("t1_w_count",  w_cnt - w0,   1);
        chk("t1_b_count",  b_cnt - b0,   1);

        // write with wready delayed 4 cycles, DECERR response
        w_dly = 4; bresp_cfg = RESP_DECERR;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        apb_xfer(1'b1, 32'h14, 32'hA5A5_0F0F, 4'b0101, 3'b000, 7, 32'h0, 1'b1);
        idle(2);
        chk("t2_aw_count", aw_cnt - aw0, 1);
        chk("t2_w_count",  w_cnt - w0,   1);
        chk("t2_b_count",  b_cnt - b0,   1);
        w_dly = 0; bresp_cfg = RESP_OKAY;

        // read with arready delayed 2 and rvalid delayed 5, SLVERR
        ar_dly = 2; r_dly = 5; rdata_cfg = 32'hCAFE_F00D; rresp_cfg = RESP_SLVERR;
        ar0 = ar_cnt; r0 = r_cnt;
        apb_xfer(1'b0, 32'h24, 32'h0, 4'h0, 3'b101, 10, 32'hCAFE_F00D, 1'b1);
        idle(2);
        chk("t3_ar_count", ar_cnt - ar0, 1);
        chk("t3_r_count",  r_cnt - r0,   1);
        ar_dly = 0; r_dly = 0;

        // back-to-back write then read, EXOKAY read
        rdata_cfg = 32'h1234_5678; rresp_cfg = RESP_EXOKAY;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
        apb_xfer(1'b1, 32'h30, 32'h0102_0304, 4'hF, 3'b000, 3, 32'h0, 1'b0);
        apb_xfer(1'b0, 32'h34, 32'h0, 4'h0, 3'b000, 3, 32'h1234_5678, 1'b0);
        idle(3);
        chk("t4_aw_count", aw_cnt - aw0, 1);
        chk("t4_w_count",  w_cnt - w0,   1);
        chk("t4_b_count",  b_cnt - b0,   1);
        chk("t4_ar_count", ar_cnt - ar0, 1);
        chk("t4_r_count",  r_cnt - r0,   1);

        // window miss on the windowed instance
        bus1.psel = 1'b1; bus1.penable = 1'b0; bus1.pwrite = 1'b1; bus1.paddr = 32'h2000;
        bus1.pwdata = 32'hFFFF_FFFF; bus1.pstrb = 4'hF;
        @(negedge clk);
        bus1.penable = 1'b1;
        chk("miss_pready_a0", bus1.pready, 1'b0);
        @(negedge clk);
        chk("miss_pready_a1", bus1.pready, 1'b0);
        @(negedge clk);
        chk("miss_pready_a2", bus1.pready,  1'b1);
        chk("miss_pslverr",   bus1.pslverr, 1'b1);
        chk("miss_prdata",    bus1.prdata,  32'h0);
        @(negedge clk);
        bus1.psel = 1'b0; bus1.penable = 1'b0;
        chk("miss_pready_once", bus1.pready, 1'b0);
        chk("miss_no_axi_activity", viol1, 1'b0);

        // asynchronous reset while arvalid is high
        ar_dly = 1000;
        bus0.psel = 1'b1; bus0.penable = 1'b0; bus0.pwrite = 1'b0; bus0.paddr = 32'h48;
        bus0.pprot = 3'b001;
        @(negedge clk);
        bus0.penable = 1'b1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus0.arvalid) seen = 1;
        end
        chk("rst_mid_arvalid_seen", seen, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_arvalid", bus0.arvalid, 1'b0);
        chk("rst_mid_pready",  bus0.pready,  1'b0);
        chk("rst_mid_rready",  bus0.rready,  1'b0);
        chk("rst_mid_araddr",  bus0.araddr,  32'h0);
        chk("rst_mid_prdata",  bus0.prdata,  32'h0);
        bus0.psel = 1'b0; bus0.penable = 1'b0;
        @(negedge clk);
        rst = 1'b1; ar_dly = 0;
        idle(2);
        rdata_cfg = 32'h0BAD_C0DE; rresp_cfg = RESP_OKAY;
        ar0 = ar_cnt; r0 = r_cnt;
        apb_xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'b001, 3, 32'h0BAD_C0DE, 1'b0);
        idle(3);
        chk("t6_ar_count", ar_cnt - ar0, 1);
        chk("t6_r_count",  r_cnt - r0,   1);

        chk("sb_aw_empty",  exp_aw.size(),  0);
        chk("sb_w_empty",   exp_w.size(),   0);
        chk("sb_ar_empty",  exp_ar.size(),  0);
        chk("sb_apb_empty", exp_apb.size(), 0);
        chk("dut1_never_axi", viol1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
